// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: MEM pipeline stage controller.
// Holds one instruction from EX, issues at most one data SRAM request for
// loads/stores, waits for the response, and presents the result to WB.
// Non-memory instructions skip straight to DONE and retire one cycle after
// acceptance.
module mem_req_ctrl (
    input  logic        clk,
    input  logic        rst,

    // EX -> MEM
    input  logic        ex_valid,
    output logic        mem_allowin,
    input  logic        ex_mem_re,
    input  logic        ex_mem_we,
    input  logic [31:0] ex_alu_res,
    input  logic [31:0] ex_wdata,
    input  logic [3:0]  ex_wstrb,
    input  logic [4:0]  ex_rf_waddr,
    input  logic        ex_rf_we,
    input  logic [31:0] ex_pc,

    // MEM -> WB
    input  logic        wb_allowin,
    output logic        mem_to_wb_valid,
    output logic [31:0] mem_result,
    output logic [4:0]  mem_rf_waddr,
    output logic        mem_rf_we,
    output logic [31:0] mem_pc,
    output logic        mem_load_pending,

    // data SRAM request/response
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_mem_re;
    logic        r_mem_we;
    logic        r_rf_we;
    logic [4:0]  r_rf_waddr;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_pc;
    logic [31:0] r_result;

    logic        w_allowin;
    logic        w_accept;

    // The stage frees up either when empty or when its result retires this edge,
    // which is what lets DONE hand over to the next instruction with no bubble.
    assign w_allowin = (r_state == ST_IDLE) | ((r_state == ST_DONE) & wb_allowin);
    assign w_accept  = ex_valid & w_allowin;

    // State machine plus all held instruction fields; the request fields only
    // change on acceptance, so they are naturally stable while REQ waits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_mem_re   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= 5'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_wstrb    <= 4'd0;
            r_pc       <= 32'd0;
            r_result   <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_mem_re   <= ex_mem_re;
                        r_mem_we   <= ex_mem_we;
                        r_rf_we    <= ex_rf_we;
                        r_rf_waddr <= ex_rf_waddr;
                        r_addr     <= ex_alu_res;
                        r_wdata    <= ex_wdata;
                        r_wstrb    <= ex_wstrb;
                        r_pc       <= ex_pc;
                        // Default result is the ALU value; a load overwrites it later.
                        r_result   <= ex_alu_res;
                        r_state    <= (ex_mem_re | ex_mem_we) ? ST_REQ : ST_DONE;
                    end else if (w_allowin) begin
                        r_state    <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (data_sram_addr_ok) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // data_ok is only meaningful here; elsewhere it is a stray
                    // response (e.g. from a transaction abandoned by reset).
                    if (data_sram_data_ok) begin
                        r_state <= ST_DONE;
                        if (r_mem_re) begin
                            r_result <= data_sram_rdata;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_allowin      = w_allowin;
    assign mem_to_wb_valid  = (r_state == ST_DONE);
    assign mem_result       = r_result;
    assign mem_rf_waddr     = r_rf_waddr;
    assign mem_rf_we        = r_rf_we & (r_state != ST_IDLE);
    assign mem_pc           = r_pc;
    assign mem_load_pending = r_mem_re & ((r_state == ST_REQ) | (r_state == ST_WAIT));

    assign data_sram_req    = (r_state == ST_REQ);
    assign data_sram_wr     = r_mem_we;
    assign data_sram_addr   = r_addr;
    assign data_sram_wdata  = r_wdata;
    // Loads never drive byte strobes even if EX left junk on ex_wstrb.
    assign data_sram_wstrb  = r_mem_we ? r_wstrb : 4'b0000;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: scoreboard bench for mem_req_ctrl.
// The driver pushes each accepted instruction's expected retirement into a
// queue; a negedge monitor compares whenever the stage presents a result, and
// a responder process models the data SRAM with per-transaction delays.
module tb_mem_req_ctrl;

    logic        clk, rst;
    logic        ex_valid, mem_allowin, ex_mem_re, ex_mem_we;
    logic [31:0] ex_alu_res, ex_wdata, ex_pc;
    logic [3:0]  ex_wstrb;
    logic [4:0]  ex_rf_waddr;
    logic        ex_rf_we;
    logic        wb_allowin, mem_to_wb_valid;
    logic [31:0] mem_result, mem_pc;
    logic [4:0]  mem_rf_waddr;
    logic        mem_rf_we, mem_load_pending;
    logic        data_sram_req, data_sram_wr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    mem_req_ctrl dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .mem_allowin(mem_allowin),
        .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we),
        .ex_alu_res(ex_alu_res), .ex_wdata(ex_wdata), .ex_wstrb(ex_wstrb),
        .ex_rf_waddr(ex_rf_waddr), .ex_rf_we(ex_rf_we), .ex_pc(ex_pc),
        .wb_allowin(wb_allowin), .mem_to_wb_valid(mem_to_wb_valid),
        .mem_result(mem_result), .mem_rf_waddr(mem_rf_waddr),
        .mem_rf_we(mem_rf_we), .mem_pc(mem_pc),
        .mem_load_pending(mem_load_pending),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [31:0] pc;
        logic [4:0]  wa;
        logic        rfwe;
        logic        re;
        int          acc;
        int          vcyc;
    } exp_t;
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } rq_t;
    typedef struct {
        int          a;
        int          w;
        logic [31:0] rdata;
    } dly_t;

    exp_t sb_q[$];
    rq_t  rq_q[$];
    dly_t dly_q[$];

    int n_chk = 0;
    int n_fail = 0;
    bit rand_wb = 0;
    int abort_req = 0;
    int stray_req = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flag(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_wb) wb_allowin = ($urandom_range(0, 3) != 0);
    endtask

    // Offer one instruction and hold it until the stage takes it. The expected
    // retirement is derived from the instruction alone: non-memory ops are
    // ready one cycle after acceptance; memory ops after a REQ cycles without
    // addr_ok, the addr_ok cycle, w WAIT cycles without data_ok, and the data_ok cycle.
    task automatic issue(input logic re, input logic we, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [3:0] ws, input logic [4:0] wa,
                         input logic rfwe, input logic [31:0] pc, input int a, input int w,
                         input logic [31:0] rdata);
        bit ok = 0;
        exp_t e;
        ex_valid = 1'b1; ex_mem_re = re; ex_mem_we = we; ex_alu_res = alu;
        ex_wdata = wd; ex_wstrb = ws; ex_rf_waddr = wa; ex_rf_we = rfwe; ex_pc = pc;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (mem_allowin) begin ok = 1; break; end
            tick();
        end
        if (!ok) begin
            flag("accept_timeout");
        end else begin
            e.res  = re ? rdata : alu;
            e.pc   = pc;
            e.wa   = wa;
            e.rfwe = rfwe;
            e.re   = re;
            e.acc  = cyc;
            e.vcyc = (re | we) ? cyc + 3 + a + w : cyc + 1;
            sb_q.push_back(e);
            if (re | we) begin
                rq_q.push_back('{wr: we, addr: alu, wdata: wd, wstrb: (we ? ws : 4'b0000)});
                dly_q.push_back('{a: a, w: w, rdata: rdata});
            end
        end
        tick();
        ex_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && sb_q.size() != 0; n++) tick();
        if (sb_q.size() != 0) flag("drain_timeout");
    endtask

    // Data SRAM model: acts just after each edge (after the driver), checks the
    // request against what the driver expects, and answers with the chosen delays.
    initial begin
        int   ph = 0;
        int   cnt = 0;
        int   nreq = 0;
        int   abort_seen = 0;
        int   stray_seen = 0;
        rq_t  r;
        dly_t d;
        r = '{wr: 1'b0, addr: 32'd0, wdata: 32'd0, wstrb: 4'd0};
        d = '{a: 0, w: 0, rdata: 32'd0};
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            data_sram_addr_ok = 1'b0;
            data_sram_data_ok = 1'b0;
            if (abort_seen != abort_req) begin
                abort_seen = abort_req;
                ph = 0;
            end
            if (ph == 0 && data_sram_req === 1'b1) begin
                if (rq_q.size() == 0 || dly_q.size() == 0) begin
                    flag("unexpected_req");
                end else begin
                    r = rq_q.pop_front();
                    d = dly_q.pop_front();
                    cnt = d.a;
                    nreq = 0;
                    ph = 1;
                end
            end
            if (ph == 1) begin
                nreq++;
                chk("req_high", data_sram_req, 1);
                chk("req_wr", data_sram_wr, r.wr);
                chk("req_addr", data_sram_addr, r.addr);
                chk("req_wdata", data_sram_wdata, r.wdata);
                chk("req_wstrb", data_sram_wstrb, r.wstrb);
                if (cnt == 0) begin
                    data_sram_addr_ok = 1'b1;
                    chk("req_cycles", nreq, d.a + 1);
                    ph = 2;
                    cnt = d.w;
                end else begin
                    cnt--;
                end
            end else if (ph == 2) begin
                chk("wait_no_req", data_sram_req, 0);
                if (cnt == 0) begin
                    data_sram_data_ok = 1'b1;
                    data_sram_rdata = r.wr ? $urandom : d.rdata;
                    ph = 0;
                end else begin
                    cnt--;
                end
            end else if (stray_seen != stray_req) begin
                stray_seen = stray_req;
                data_sram_data_ok = 1'b1;
                data_sram_rdata = $urandom;
            end
        end
    end

    // Monitor: every cycle the stage is either presenting the head of the
    // scoreboard, working on it, or empty.
    initial begin
        bit newi = 1;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                newi = 1;
            end else if (mem_to_wb_valid) begin
                if (sb_q.size() == 0) begin
                    flag("unexpected_valid");
                end else begin
                    e = sb_q[0];
                    if (newi) begin
                        chk("latency", cyc, e.vcyc);
                        newi = 0;
                    end
                    chk("result", mem_result, e.res);
                    chk("pc", mem_pc, e.pc);
                    chk("waddr", mem_rf_waddr, e.wa);
                    chk("rf_we", mem_rf_we, e.rfwe);
                    chk("done_pending", mem_load_pending, 0);
                    chk("done_allowin", mem_allowin, wb_allowin);
                    chk("done_no_req", data_sram_req, 0);
                    if (wb_allowin) begin
                        void'(sb_q.pop_front());
                        newi = 1;
                    end
                end
            end else if (sb_q.size() != 0 && cyc > sb_q[0].acc) begin
                e = sb_q[0];
                chk("busy_allowin", mem_allowin, 0);
                chk("busy_pending", mem_load_pending, e.re);
                chk("busy_rf_we", mem_rf_we, e.rfwe);
            end else begin
                chk("idle_allowin", mem_allowin, 1);
                chk("idle_rf_we", mem_rf_we, 0);
                chk("idle_pending", mem_load_pending, 0);
                chk("idle_no_req", data_sram_req, 0);
            end
        end
    end

    // Everything that reset must clear.
    task automatic chk_cleared(input string tag);
        chk({tag, "_valid"}, mem_to_wb_valid, 0);
        chk({tag, "_allowin"}, mem_allowin, 1);
        chk({tag, "_result"}, mem_result, 0);
        chk({tag, "_pc"}, mem_pc, 0);
        chk({tag, "_waddr"}, mem_rf_waddr, 0);
        chk({tag, "_rf_we"}, mem_rf_we, 0);
        chk({tag, "_pending"}, mem_load_pending, 0);
        chk({tag, "_req"}, data_sram_req, 0);
        chk({tag, "_wr"}, data_sram_wr, 0);
        chk({tag, "_addr"}, data_sram_addr, 0);
        chk({tag, "_wdata"}, data_sram_wdata, 0);
        chk({tag, "_wstrb"}, data_sram_wstrb, 0);
    endtask

    initial begin
        rst = 1'b1; wb_allowin = 1'b1; ex_valid = 1'b0; ex_mem_re = 1'b0; ex_mem_we = 1'b0;
        ex_alu_res = 32'd0; ex_wdata = 32'd0; ex_wstrb = 4'd0; ex_rf_waddr = 5'd0;
        ex_rf_we = 1'b0; ex_pc = 32'd0;
        repeat (2) tick();
        @(negedge clk);
        chk_cleared("reset");
        tick();
        rst = 1'b0;

        // ALU op
        issue(0, 0, 32'h0000_1234, 32'd0, 4'd0, 5'd5, 1, 32'h1C00_0000, 0, 0, 32'd0);
        drain();

        // Load: addr_ok after 2 idle REQ cycles, data_ok 3 cycles after addr_ok
        issue(1, 0, 32'h1C00_0100, 32'h1111_2222, 4'b1111, 5'd7, 1, 32'h1C00_0004, 2, 2,
              32'hDEAD_BEEF);
        drain();

        // Store
        issue(0, 1, 32'h1C00_0300, 32'h0000_A5A5, 4'b0011, 5'd0, 0, 32'h1C00_0008, 1, 1,
              32'd0);
        drain();

        // Backpressure in DONE, then back-to-back hand-over
        tick();
        wb_allowin = 1'b0;
        issue(0, 0, 32'hCAFE_F00D, 32'd0, 4'd0, 5'd9, 1, 32'h1C00_000C, 0, 0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_allowin", mem_allowin, 0);
            chk("bp_valid", mem_to_wb_valid, 1);
            chk("bp_result", mem_result, 32'hCAFE_F00D);
            chk("bp_waddr", mem_rf_waddr, 5'd9);
            tick();
        end
        wb_allowin = 1'b1;
        issue(0, 0, 32'h0BAD_CAFE, 32'd0, 4'd0, 5'd10, 1, 32'h1C00_0010, 0, 0, 32'd0);
        drain();

        // Reset while waiting for data, then a stray data_ok
        issue(1, 0, 32'h1C00_0200, 32'd0, 4'd0, 5'd3, 1, 32'h1C00_0014, 0, 20, 32'h1234_5678);
        repeat (3) tick();
        rst = 1'b1;
        abort_req++;
        sb_q.delete();
        tick();
        rst = 1'b0;
        stray_req++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_cleared("abort");
            tick();
        end

        // Stray data_ok while idle after a retired instruction
        issue(0, 0, 32'h0000_0042, 32'd0, 4'd0, 5'd1, 1, 32'h1C00_0018, 0, 0, 32'd0);
        drain();
        stray_req++;
        repeat (2) tick();
        @(negedge clk);
        chk("stray_valid", mem_to_wb_valid, 0);
        chk("stray_allowin", mem_allowin, 1);
        chk("stray_pending", mem_load_pending, 0);

        // Random mix with random WB backpressure and SRAM delays
        tick();
        rand_wb = 1;
        for (int i = 0; i < 150; i++) begin
            int k;
            k = $urandom_range(0, 2);
            issue(k == 1, k == 2, $urandom, $urandom, 4'($urandom_range(0, 15)),
                  5'($urandom_range(0, 31)), (k == 2) ? 1'b0 : 1'($urandom_range(0, 1)),
                  $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();
        rand_wb = 0;
        wb_allowin = 1'b1;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
